// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: one shared decoder multiplexed over the anodes.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN suppresses leading-zero digits at commit.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    CLK100MHZ,
    input  logic                    CPU_RESETN,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   digit_en_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [3:0]              HEX,
    output logic [7:0]              AN,
    output logic                    DP,
    output logic                    frame_done,
    output logic                    update_pending
);

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } state_t;

    localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] BLANK_N = DW'(BLANK_CYCLES);
    localparam logic [2:0] SLOT_LAST = 3'(NUM_DIGITS - 1);
    localparam state_t ST_RST = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;

    // Scan position
    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nxt;
    logic [2:0]    slot;
    logic [2:0]    slot_nxt;
    logic          wrap;
    logic          boundary;
    state_t        state;
    state_t        state_nxt;

    // Inputs padded to the full eight-digit width
    logic [31:0] in_val;
    logic [7:0]  in_en;
    logic [7:0]  in_dp;

    // Pending and active frame buffers
    logic [31:0] pend_val;
    logic [7:0]  pend_en;
    logic [7:0]  pend_dp;
    logic [31:0] act_val;
    logic [7:0]  act_en;
    logic [7:0]  act_dp;

    // Commit path
    logic        commit;
    logic [31:0] src_val;
    logic [7:0]  src_en;
    logic [7:0]  src_dp;
    logic [7:0]  commit_en;

    // Next registered outputs
    logic [7:0] an_nxt;
    logic [3:0] hex_nxt;
    logic       dp_nxt;

    assign in_val = 32'(value_in);
    assign in_en  = 8'(digit_en_in);
    assign in_dp  = 8'(dp_in);

    assign wrap     = (div_cnt == DIV_LAST);
    assign boundary = wrap && (slot == SLOT_LAST);

    // A load on the boundary bypasses the pending buffer
    assign commit  = boundary && (load || update_pending);
    assign src_val = load ? in_val : pend_val;
    assign src_en  = load ? in_en : pend_en;
    assign src_dp  = load ? in_dp : pend_dp;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Clear enables of the zero run starting at the top digit; digit 0 always stays
    function automatic logic [7:0] lz_mask(input logic [31:0] v);
        logic [7:0] m;
        logic       zrun;
        m    = 8'hFF;
        zrun = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            zrun = zrun && (v[4*i +: 4] == 4'd0);
            if (zrun) begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction
`else
    // Enables pass through unchanged
    function automatic logic [7:0] lz_mask(input logic [31:0] v);
        logic unused;
        unused = ^v;
        return 8'hFF;
    endfunction
`endif

    // Clearing the enable also clears the decimal point on the pin
    assign commit_en = src_en & lz_mask(src_val);

    // Divider, slot counter and phase register
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            div_cnt <= '0;
            slot    <= '0;
            state   <= ST_RST;
        end else begin
            div_cnt <= div_nxt;
            slot    <= slot_nxt;
            state   <= state_nxt;
        end
    end

    // Next scan position; the phase follows the divider alone
    always_comb begin
        div_nxt   = div_cnt + 1'b1;
        slot_nxt  = slot;
        state_nxt = ST_DRIVE;
        if (wrap) begin
            div_nxt  = '0;
            slot_nxt = (slot == SLOT_LAST) ? 3'd0 : slot + 3'd1;
        end
        if (div_nxt < BLANK_N) begin
            state_nxt = ST_BLANK;
        end
    end

    // Output decode for the current slot; HEX settles during the blank gap
    always_comb begin
        an_nxt  = 8'hFF;
        dp_nxt  = 1'b1;
        hex_nxt = act_val[{slot, 2'b00} +: 4];
        unique case (state)
            ST_BLANK: begin
                an_nxt = 8'hFF;
            end
            ST_DRIVE: begin
                an_nxt[slot] = ~act_en[slot];
                dp_nxt       = ~(act_dp[slot] & act_en[slot]);
            end
            default: begin
                an_nxt = 8'hFF;
            end
        endcase
    end

    // Pending capture and frame-boundary commit into the active buffer
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            pend_val       <= '0;
            pend_en        <= '0;
            pend_dp        <= '0;
            act_val        <= '0;
            act_en         <= '0;
            act_dp         <= '0;
            update_pending <= 1'b0;
        end else begin
            if (load) begin
                pend_val <= in_val;
                pend_en  <= in_en;
                pend_dp  <= in_dp;
            end
            if (commit) begin
                act_val <= src_val;
                act_en  <= commit_en;
                act_dp  <= src_dp;
            end
            if (boundary) begin
                update_pending <= 1'b0;
            end else if (load) begin
                update_pending <= 1'b1;
            end
        end
    end

    // Registered pin drivers; reset blanks the display without a clock
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            AN         <= 8'hFF;
            HEX        <= 4'd0;
            DP         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            AN         <= an_nxt;
            HEX        <= hex_nxt;
            DP         <= dp_nxt;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random loads,
// checked every cycle against a frame-level reference model.
module tb_seg_scan_ctrl;

    localparam int ND = 8;
    localparam int RD = 8;
    localparam int BC = 2;

    logic        CLK100MHZ;
    logic        CPU_RESETN;
    logic        load;
    logic [31:0] value_in;
    logic [7:0]  digit_en_in;
    logic [7:0]  dp_in;
    logic [3:0]  HEX;
    logic [7:0]  AN;
    logic        DP;
    logic        frame_done;
    logic        update_pending;

    int checks = 0;
    int errors = 0;

    // Reference model: cycle index since reset release and the two buffers
    int          t;
    int          act_val[8];
    bit          act_en[8];
    bit          act_dp[8];
    logic [31:0] pend_v;
    logic [7:0]  pend_e;
    logic [7:0]  pend_d;
    bit          pend_f;
    logic [7:0]  last_an;

    seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .CLK100MHZ     (CLK100MHZ),
        .CPU_RESETN    (CPU_RESETN),
        .load          (load),
        .value_in      (value_in),
        .digit_en_in   (digit_en_in),
        .dp_in         (dp_in),
        .HEX           (HEX),
        .AN            (AN),
        .DP            (DP),
        .frame_done    (frame_done),
        .update_pending(update_pending)
    );

    initial CLK100MHZ = 1'b0;
    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < 8; i++) begin
            act_val[i] = 0;
            act_en[i]  = 1'b0;
            act_dp[i]  = 1'b0;
        end
        pend_v = '0;
        pend_e = '0;
        pend_d = '0;
        pend_f = 1'b0;
    endtask

    // Copy a frame into the active buffer; optionally hide leading zeros
    task automatic model_commit(input logic [31:0] v, input logic [7:0] e,
                                input logic [7:0] d);
        int top;
        top = 0;
        for (int i = 0; i < 8; i++) begin
            act_val[i] = int'(v[4*i +: 4]);
            act_en[i]  = e[i];
            act_dp[i]  = d[i];
            if (v[4*i +: 4] != 4'd0) top = i;
        end
`ifdef SEG_LEADING_ZERO_BLANK_EN
        for (int i = 0; i < 8; i++) begin
            if (i > top) act_en[i] = 1'b0;
        end
`endif
    endtask

    // One clock: drive inputs, predict registered outputs, compare after the edge
    task automatic step(input bit ld, input logic [31:0] v,
                        input logic [7:0] e, input logic [7:0] d);
        int       phase;
        int       sl;
        bit       blank;
        bit       bnd;
        logic [7:0] x_an;
        logic [3:0] x_hex;
        logic       x_dp;
        phase = t % RD;
        sl    = (t / RD) % ND;
        blank = (phase < BC);
        bnd   = (phase == RD - 1) && (sl == ND - 1);
        load        = ld;
        value_in    = v;
        digit_en_in = e;
        dp_in       = d;
        x_an  = 8'hFF;
        x_dp  = 1'b1;
        x_hex = 4'(act_val[sl]);
        if (!blank) begin
            if (act_en[sl]) x_an[sl] = 1'b0;
            x_dp = ~(act_dp[sl] & act_en[sl]);
        end
        if (bnd) begin
            if (ld) model_commit(v, e, d);
            else if (pend_f) model_commit(pend_v, pend_e, pend_d);
            pend_f = 1'b0;
        end else if (ld) begin
            pend_f = 1'b1;
        end
        if (ld) begin
            pend_v = v;
            pend_e = e;
            pend_d = d;
        end
        @(posedge CLK100MHZ);
        #1;
        load = 1'b0;
        t++;
        last_an = x_an;
        chk("an", 32'(AN), 32'(x_an));
        chk("hex", 32'(HEX), 32'(x_hex));
        chk("dp", 32'(DP), 32'(x_dp));
        chk("frame_done", 32'(frame_done), 32'(bnd));
        chk("upd", 32'(update_pending), 32'(pend_f));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, value_in, digit_en_in, dp_in);
    endtask

    task automatic to_boundary();
        while ((t % (RD * ND)) != RD * ND - 1) idle(1);
    endtask

    initial begin
        bit found;
        CPU_RESETN  = 1'b0;
        load        = 1'b0;
        value_in    = '0;
        digit_en_in = '0;
        dp_in       = '0;
        last_an     = 8'hFF;
        model_reset();
        #23;
        chk("rst_an", 32'(AN), 32'hFF);
        chk("rst_hex", 32'(HEX), 32'h0);
        chk("rst_dp", 32'(DP), 32'h1);
        chk("rst_fd", 32'(frame_done), 32'h0);
        chk("rst_upd", 32'(update_pending), 32'h0);
        @(posedge CLK100MHZ);
        #1;
        CPU_RESETN = 1'b1;

        // Free-running scan with nothing loaded
        idle(140);

        // Basic display
        step(1'b1, 32'h1234ABCD, 8'hFF, 8'h00);
        idle(140);

        // Double buffer: two loads inside one frame, last wins
        idle(20);
        step(1'b1, 32'hAAAA5555, 8'hFF, 8'h0F);
        idle(9);
        step(1'b1, 32'h9876FEDC, 8'hF0, 8'hFF);
        idle(140);

        // Load on the boundary cycle commits directly
        to_boundary();
        step(1'b1, 32'h00000005, 8'hFF, 8'h00);
        idle(70);

        // Sparse enables and decimal points
        step(1'b1, 32'h76543210, 8'h05, 8'h07);
        idle(140);

        // Leading-zero pattern
        step(1'b1, 32'h00000305, 8'hFF, 8'h00);
        idle(140);

        // Random loads
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0)
                step(1'b1, $urandom, 8'($urandom), 8'($urandom));
            else
                idle(1);
        end

        // Asynchronous reset while a digit is driven
        step(1'b1, 32'h00000305, 8'hFF, 8'hFF);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            idle(1);
            if (last_an != 8'hFF && t > 80) found = 1'b1;
        end
        chk("drive_reached", 32'(found), 32'h1);
        CPU_RESETN = 1'b0;
        #1;
        chk("arst_an", 32'(AN), 32'hFF);
        chk("arst_dp", 32'(DP), 32'h1);
        chk("arst_hex", 32'(HEX), 32'h0);
        chk("arst_upd", 32'(update_pending), 32'h0);
        @(posedge CLK100MHZ);
        #2;
        chk("arst_hold_an", 32'(AN), 32'hFF);
        CPU_RESETN = 1'b1;
        model_reset();
        idle(140);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
